sq_mwi: RTL and testbench



---
 rtl/sq_mwi_pkg.sv | 17 +
 rtl/sq_mwi_ring.sv | 37 +++
 rtl/sq_mwi.sv | 83 ++++++++
 tb/tb_sq_mwi.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_mwi_pkg.sv
// Shared constants for the squaring / moving-window-integration stage of the
// QRS detection chain.
package sq_mwi_pkg;

    localparam int DATA_INPUT   = 8;
    localparam int SLOPE_OFFSET = 256;
    localparam int MWI_WIN_LOG2 = 5;

    // One square of a 10-bit signed slope (max 65536) needs 17 bits.
    localparam int SQ_W = 17;

    // The accumulator must hold N full-scale squares without wrapping.
    function automatic int sum_width(input int win_log2);
        return SQ_W + win_log2;
    endfunction

endpackage

// File: rtl/sq_mwi_ring.sv
// Circular buffer of the last N squares: combinational read at the write
// pointer, synchronous write, and synchronous clear of every entry.
module mwi_ring
    import sq_mwi_pkg::*;
#(
    parameter int WIN_LOG2 = MWI_WIN_LOG2,
    parameter int W        = SQ_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    localparam int N = 1 << WIN_LOG2;

    logic [W-1:0]        mem [N];
    logic [WIN_LOG2-1:0] wp;

    // The slot about to be overwritten is the oldest sample in the window.
    assign rdata = mem[wp];

    // N is a power of two, so the pointer wraps N-1 -> 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wp] <= wdata;
            wp      <= wp + 1'b1;
        end
    end

endmodule

// File: rtl/sq_mwi.sv
// Squarer plus moving-window integrator: removes the slope offset, squares,
// and reports the average of the last 2^WIN_LOG2 squares.
module sq_mwi
    import sq_mwi_pkg::*;
#(
    parameter int DW       = DATA_INPUT + 1,
    parameter int OFFSET   = SLOPE_OFFSET,
    parameter int WIN_LOG2 = MWI_WIN_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   d_in,
    input  logic            in_valid,
    output logic [SQ_W-1:0] y_out,
    output logic            out_valid,
    output logic            primed
);

    localparam int N     = 1 << WIN_LOG2;
    localparam int SUM_W = sum_width(WIN_LOG2);
    localparam int CNT_W = WIN_LOG2 + 1;

    logic signed [DW:0]     slope;
    logic signed [SQ_W-1:0] slope_ext;
    logic [SQ_W-1:0]        sq_next;
    logic [SQ_W-1:0]        sq_r;
    logic [SQ_W-1:0]        oldest;
    logic [SUM_W-1:0]       sum_r;
    logic [CNT_W-1:0]       cnt;
    logic                   v1;
    logic                   v2;

    // Sign-extend before squaring so (-256)^2 = 65536 lands in 17 bits intact.
    assign slope     = $signed({1'b0, d_in}) - $signed((DW + 1)'(OFFSET));
    assign slope_ext = SQ_W'(slope);
    assign sq_next   = $unsigned(slope_ext * slope_ext);

    mwi_ring #(
        .WIN_LOG2(WIN_LOG2),
        .W       (SQ_W)
    ) u_ring (
        .clk  (clk),
        .rst  (rst),
        .we   (v1),
        .wdata(sq_r),
        .rdata(oldest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_r      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sum_r     <= '0;
            cnt       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                sq_r <= sq_next;
            end

            v2 <= v1;
            if (v1) begin
                sum_r <= sum_r + SUM_W'(sq_r) - SUM_W'(oldest);
                if (cnt != CNT_W'(N)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // cnt hits N one edge after the Nth sample enters the sum,
            // which lines primed up with that sample's output strobe.
            primed    <= (cnt == CNT_W'(N));
            out_valid <= v2;
            if (v2) begin
                y_out <= SQ_W'(sum_r >> WIN_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_sq_mwi.sv
// Directed self-checking bench for sq_mwi with default parameters (N = 32).
module tb_sq_mwi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  d_in = 9'd256;
    logic        in_valid = 1'b0;
    logic [16:0] y_out;
    logic        out_valid;
    logic        primed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int y_q[$];
    int p_q[$];
    int c_q[$];

    sq_mwi dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .in_valid (in_valid),
        .y_out    (y_out),
        .out_valid(out_valid),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    // Strobe monitor: records value, primed flag and edge number of every output.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_valid === 1'b1) begin
            y_q.push_back(int'(y_out));
            p_q.push_back(int'(primed));
            c_q.push_back(cyc);
        end
    end

    task automatic drive(input logic v, input int d);
        @(negedge clk);
        in_valid = v;
        d_in     = 9'(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 256);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_q();
        y_q.delete();
        p_q.delete();
        c_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        d_in     = 9'd256;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_reset();
        int acc;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        d_in     = 9'd300;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (y_out !== 17'd0) begin
                errors++;
                $display("[TB] FAIL reset_y cycle %0d: got %0d, expected 0", i, y_out);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out_valid cycle %0d: got %b, expected 0", i, out_valid);
            end
            checks++;
            if (primed !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_primed cycle %0d: got %b, expected 0", i, primed);
            end
        end
        @(negedge clk);
        clear_q();
        rst = 1'b0;
        acc = cyc + 1;
        drive(1'b0, 256);
        idle(4);
        // 300 - 256 = 44, 44^2 = 1936, 1936 >> 5 = 60
        checks++;
        if (y_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL release_strobes: got %0d, expected 1", y_q.size());
        end else begin
            checks++;
            if (y_q[0] != 60) begin
                errors++;
                $display("[TB] FAIL release_y: got %0d, expected 60", y_q[0]);
            end
            checks++;
            if (c_q[0] != acc + 2) begin
                errors++;
                $display("[TB] FAIL release_latency: got edge %0d, expected edge %0d", c_q[0], acc + 2);
            end
        end
    endtask

    task automatic test_zero_slope();
        do_reset();
        for (int i = 0; i < 100; i++) drive(1'b1, 256);
        idle(4);
        checks++;
        if (y_q.size() != 100) begin
            errors++;
            $display("[TB] FAIL zero_strobes: got %0d, expected 100", y_q.size());
        end
        for (int i = 0; i < y_q.size(); i++) begin
            checks++;
            if (y_q[i] != 0) begin
                errors++;
                $display("[TB] FAIL zero_y strobe %0d: got %0d, expected 0", i + 1, y_q[i]);
            end
            checks++;
            if (p_q[i] != ((i >= 31) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL zero_primed strobe %0d: got %0d, expected %0d",
                         i + 1, p_q[i], (i >= 31) ? 1 : 0);
            end
        end
    endtask

    task automatic test_impulse();
        int exp_y;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 256);
        drive(1'b1, 266);
        for (int i = 0; i < 40; i++) drive(1'b1, 256);
        idle(4);
        checks++;
        if (y_q.size() != 46) begin
            errors++;
            $display("[TB] FAIL impulse_strobes: got %0d, expected 46", y_q.size());
        end
        // impulse is strobe index 5 and stays in the window through index 36
        for (int i = 0; i < y_q.size(); i++) begin
            exp_y = (i >= 5 && i <= 36) ? 3 : 0;
            checks++;
            if (y_q[i] != exp_y) begin
                errors++;
                $display("[TB] FAIL impulse_y strobe %0d: got %0d, expected %0d", i, y_q[i], exp_y);
            end
        end
    endtask

    task automatic test_back_to_back_ramp();
        int k;
        int exp_y;
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, 511);
        idle(4);
        checks++;
        if (y_q.size() != 40) begin
            errors++;
            $display("[TB] FAIL ramp_strobes: got %0d, expected 40", y_q.size());
        end
        for (int i = 0; i < y_q.size(); i++) begin
            k = (i + 1 > 32) ? 32 : i + 1;
            exp_y = (k * 65025) / 32;
            checks++;
            if (y_q[i] != exp_y) begin
                errors++;
                $display("[TB] FAIL ramp_y strobe %0d: got %0d, expected %0d", i + 1, y_q[i], exp_y);
            end
            checks++;
            if (c_q[i] != c_q[0] + i) begin
                errors++;
                $display("[TB] FAIL ramp_spacing strobe %0d: got edge %0d, expected %0d",
                         i + 1, c_q[i], c_q[0] + i);
            end
            checks++;
            if (p_q[i] != ((i >= 31) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL ramp_primed strobe %0d: got %0d, expected %0d",
                         i + 1, p_q[i], (i >= 31) ? 1 : 0);
            end
        end
    endtask

    task automatic test_neg_full();
        int exp_y;
        do_reset();
        for (int i = 0; i < 32; i++) drive(1'b1, 0);
        for (int i = 0; i < 32; i++) drive(1'b1, 256);
        idle(4);
        checks++;
        if (y_q.size() != 64) begin
            errors++;
            $display("[TB] FAIL negfull_strobes: got %0d, expected 64", y_q.size());
        end
        // each -256 sample contributes 65536 / 32 = 2048
        for (int i = 0; i < y_q.size(); i++) begin
            exp_y = (i < 32) ? (i + 1) * 2048 : (63 - i) * 2048;
            checks++;
            if (y_q[i] != exp_y) begin
                errors++;
                $display("[TB] FAIL negfull_y strobe %0d: got %0d, expected %0d", i + 1, y_q[i], exp_y);
            end
        end
    endtask

    task automatic test_gaps();
        int k;
        int exp_y;
        do_reset();
        // first accepted sample +100 (square 10000), the rest +10 (square 100);
        // gap cycles carry junk that must be ignored
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i == 0) ? 356 : 266);
            drive(1'b0, 511);
        end
        idle(4);
        checks++;
        if (y_q.size() != 40) begin
            errors++;
            $display("[TB] FAIL gaps_strobes: got %0d, expected 40", y_q.size());
        end
        for (int i = 0; i < y_q.size(); i++) begin
            k = i + 1;
            exp_y = (k <= 32) ? (10000 + (k - 1) * 100) / 32 : 100;
            checks++;
            if (y_q[i] != exp_y) begin
                errors++;
                $display("[TB] FAIL gaps_y strobe %0d: got %0d, expected %0d", k, y_q[i], exp_y);
            end
            if (i > 0) begin
                checks++;
                if (c_q[i] - c_q[i-1] != 2) begin
                    errors++;
                    $display("[TB] FAIL gaps_spacing strobe %0d: got %0d, expected 2", k, c_q[i] - c_q[i-1]);
                end
            end
            checks++;
            if (p_q[i] != ((i >= 31) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL gaps_primed strobe %0d: got %0d, expected %0d",
                         k, p_q[i], (i >= 31) ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp_y;
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 511);
        // reset wins over a valid sample presented in the same cycle
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        d_in     = 9'd511;
        @(posedge clk);
        #1;
        clear_q();
        checks++;
        if (primed !== 1'b0 || out_valid !== 1'b0 || y_out !== 17'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got y=%0d ov=%b pr=%b, expected 0 0 0",
                     y_out, out_valid, primed);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        d_in     = 9'd266;
        for (int i = 0; i < 40; i++) drive(1'b1, 256);
        idle(4);
        checks++;
        if (y_q.size() != 41) begin
            errors++;
            $display("[TB] FAIL midreset_strobes: got %0d, expected 41", y_q.size());
        end
        for (int i = 0; i < y_q.size(); i++) begin
            exp_y = (i <= 31) ? 3 : 0;
            checks++;
            if (y_q[i] != exp_y) begin
                errors++;
                $display("[TB] FAIL midreset_y strobe %0d: got %0d, expected %0d", i + 1, y_q[i], exp_y);
            end
            checks++;
            if (p_q[i] != ((i >= 31) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL midreset_primed strobe %0d: got %0d, expected %0d",
                         i + 1, p_q[i], (i >= 31) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_slope();
        test_impulse();
        test_back_to_back_ramp();
        test_neg_full();
        test_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
